// File: rtl/spi_fpga_slave_sync.sv
// SPI slave running entirely in the fabric clock domain. SCLK, CS and MOSI
// are oversampled through two-flop synchronizers; SCLK/CS edges are found
// by comparing the synchronized value against one extra history flop.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | CS inactive, MISO not driven, SCLK edges ignored
// SHIFT | CS active, packs shifted in/out, back-to-back allowed
`timescale 1ns/1ps

module spi_fpga_slave_sync #(
    parameter int   CLOCK_FREQUENCY            = 50000000,
    parameter int   PACK_LENGTH                = 8,
    parameter logic CPOL                       = 1'b1,
    parameter logic CPHA                       = 1'b0,
    parameter int   PACK_BIT_SEQUENCE_TRANSMIT = 0,
    parameter int   PACK_BIT_SEQUENCE_RECEIVE  = 1,
    parameter int   PACK_LENGTH_LOG_2          = $clog2(PACK_LENGTH) + 1
) (
    input  logic                   IN_CLOCK,
    input  logic                   IN_RESET_N,
    input  logic                   IN_SCLK,
    input  logic                   IN_CS,
    input  logic                   IN_MOSI,
    input  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA,
    output logic                   OUT_MISO,
    output logic                   OUT_MISO_OE,
    output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
    output logic                   OUT_RECEIVE_VALID,
    output logic                   OUT_TRANSMIT_LOADED,
    output logic                   OUT_BUSY,
    output logic                   OUT_FRAME_ERROR
);

    localparam int CW = PACK_LENGTH_LOG_2;
    localparam logic [CW-1:0] CNT_LAST = CW'(PACK_LENGTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Parameter sanity: the SCLK timing limits are relative to CLOCK_FREQUENCY,
    // so a non-positive value can only be a configuration mistake.
    if (PACK_LENGTH < 2) begin : g_bad_pack_length
        $error("PACK_LENGTH must be at least 2");
    end
    if (CLOCK_FREQUENCY <= 0) begin : g_bad_clock_frequency
        $error("CLOCK_FREQUENCY must be positive");
    end
    if ((1 << PACK_LENGTH_LOG_2) <= PACK_LENGTH) begin : g_bad_counter_width
        $error("PACK_LENGTH_LOG_2 too small to hold PACK_LENGTH");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic sclk_meta, sclk_sync, sclk_hist;
    logic cs_meta, cs_sync, cs_hist;
    logic mosi_meta, mosi_sync;

    logic sclk_lead, sclk_trail, cs_fall, cs_rise;
    logic sample_edge, shift_edge;

    logic start, stop, do_sample, do_shift, busy;

    logic [PACK_LENGTH-1:0] tx_sr;
    logic [PACK_LENGTH-1:0] rx_sr;
    logic [PACK_LENGTH-1:0] rx_next;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_inc;
    logic                   miso;
    logic [PACK_LENGTH-1:0] rx_data;
    logic                   rx_valid;
    logic                   tx_loaded;
    logic                   frame_err;

    // Bit presented first on MISO from a given pack image.
    function automatic logic tx_first(input logic [PACK_LENGTH-1:0] x);
        return (PACK_BIT_SEQUENCE_TRANSMIT != 0) ? x[PACK_LENGTH-1] : x[0];
    endfunction

    // Pack image with the just-presented bit consumed.
    function automatic logic [PACK_LENGTH-1:0] tx_advance(input logic [PACK_LENGTH-1:0] x);
        return (PACK_BIT_SEQUENCE_TRANSMIT != 0) ? {x[PACK_LENGTH-2:0], 1'b0}
                                                 : {1'b0, x[PACK_LENGTH-1:1]};
    endfunction

    // Two-flop synchronizers plus history flops, reset to bus idle levels.
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            sclk_meta <= CPOL;
            sclk_sync <= CPOL;
            sclk_hist <= CPOL;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_hist   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sclk_meta <= IN_SCLK;
            sclk_sync <= sclk_meta;
            sclk_hist <= sclk_sync;
            cs_meta   <= IN_CS;
            cs_sync   <= cs_meta;
            cs_hist   <= cs_sync;
            mosi_meta <= IN_MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    assign sclk_lead   = (sclk_sync != CPOL) && (sclk_hist == CPOL);
    assign sclk_trail  = (sclk_sync == CPOL) && (sclk_hist != CPOL);
    assign cs_fall     = !cs_sync && cs_hist;
    assign cs_rise     = cs_sync && !cs_hist;
    assign sample_edge = CPHA ? sclk_trail : sclk_lead;
    assign shift_edge  = CPHA ? sclk_lead : sclk_trail;

    // State register.
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: CS alone opens and closes a transfer window.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = SHIFT;
            SHIFT:   if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-state control decode; a CS release masks any coincident SCLK edge.
    always_comb begin
        start     = 1'b0;
        stop      = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                start = cs_fall;
            end
            SHIFT: begin
                busy      = 1'b1;
                stop      = cs_rise;
                do_sample = !cs_rise && sample_edge;
                do_shift  = !cs_rise && shift_edge;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign rx_next = (PACK_BIT_SEQUENCE_RECEIVE != 0) ? {rx_sr[PACK_LENGTH-2:0], mosi_sync}
                                                      : {mosi_sync, rx_sr[PACK_LENGTH-1:1]};
    assign cnt_inc = cnt + CNT_ONE;

    // Shift datapath, pack hand-off and strobes.
    // In CPHA=0 the first bit must already be on MISO before the first
    // leading edge, so it is consumed at load; in CPHA=1 the leading edge
    // presents it. At pack completion the full image is reloaded so the
    // next shift edge presents the new pack's first bit.
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            tx_sr     <= '0;
            rx_sr     <= '0;
            cnt       <= '0;
            miso      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_loaded <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_loaded <= 1'b0;
            frame_err <= 1'b0;
            if (start) begin
                tx_sr     <= CPHA ? IN_TRANSMIT_DATA : tx_advance(IN_TRANSMIT_DATA);
                miso      <= CPHA ? 1'b0 : tx_first(IN_TRANSMIT_DATA);
                rx_sr     <= '0;
                cnt       <= '0;
                tx_loaded <= 1'b1;
            end else if (stop) begin
                miso      <= 1'b0;
                cnt       <= '0;
                frame_err <= (cnt != '0);
            end else begin
                if (do_sample) begin
                    rx_sr <= rx_next;
                    if (cnt_inc == CNT_LAST) begin
                        rx_data   <= rx_next;
                        rx_valid  <= 1'b1;
                        cnt       <= '0;
                        tx_sr     <= IN_TRANSMIT_DATA;
                        tx_loaded <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                if (do_shift) begin
                    miso  <= tx_first(tx_sr);
                    tx_sr <= tx_advance(tx_sr);
                end
            end
        end
    end

    assign OUT_MISO            = miso;
    assign OUT_MISO_OE         = busy;
    assign OUT_BUSY            = busy;
    assign OUT_RECEIVE_DATA    = rx_data;
    assign OUT_RECEIVE_VALID   = rx_valid;
    assign OUT_TRANSMIT_LOADED = tx_loaded;
    assign OUT_FRAME_ERROR     = frame_err;

endmodule
